sdram_arbiter: RTL and testbench

- Two-port request arbiter directly upstream of the byte-wide SDRAM controller. It multiplexes a CPU port and a DMA/loader port onto the controller's edge-triggered rd/we strobes.
- It tracks the controller's ready flag, including same-word read hits where ready never drops. It returns read data and a one-cycle ack to the granted port.
- Fixed CPU priority, with an anti-starvation counter that guarantees DMA service.

---
 rtl/sdram_arbiter.sv | 137 +++++++++++++
 tb/tb_sdram_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port (CPU/DMA) arbiter in front of the byte-wide SDRAM controller.
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : sdram_arbiter                                              |
// | Description : Fixed-priority CPU/DMA arbiter with DMA anti-starvation,   |
// |               edge-triggered rd/we strobes and ready tracking.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sdram_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DMA_MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_we,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic [24:0] dma_addr,
  input  logic [7:0]  dma_din,
  input  logic        dma_rd,
  input  logic        dma_we,
  output logic [7:0]  dma_dout,
  output logic        dma_ack,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        sd_rd,
  output logic        sd_we,
  input  logic [7:0]  sd_dout,
  input  logic        sd_ready
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW  = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(DMA_MAX_WAIT);
  localparam logic [SCW-1:0] SETTLE_INIT = SCW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]     state;
  logic [SCW-1:0] settle_cnt;
  logic [SW-1:0]  starve_cnt;
  logic           grant;      // 0 = CPU, 1 = DMA
  logic           op_write;

  logic cpu_req;
  logic dma_req;
  logic dma_pending;
  logic pick_dma;

  // A port is masked during its ack cycle so a still-held request is not serviced twice.
  always_comb begin
    cpu_req     = (cpu_rd | cpu_we) & ~cpu_ack;
    dma_req     = (dma_rd | dma_we) & ~dma_ack;
    dma_pending = dma_rd | dma_we;
    pick_dma    = dma_req & (~cpu_req | (starve_cnt == STARVE_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      starve_cnt <= '0;
      grant      <= 1'b0;
      op_write   <= 1'b0;
      sd_addr    <= '0;
      sd_din     <= '0;
      sd_rd      <= 1'b0;
      sd_we      <= 1'b0;
      cpu_dout   <= '0;
      dma_dout   <= '0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      sd_rd   <= 1'b0;
      sd_we   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sd_ready && (cpu_req || dma_req)) begin
            state <= S_STROBE;
            grant <= pick_dma;
            if (pick_dma) begin
              sd_addr    <= dma_addr;
              sd_din     <= dma_din;
              op_write   <= dma_we;
              sd_rd      <= ~dma_we;
              sd_we      <= dma_we;
              starve_cnt <= '0;
            end else begin
              sd_addr  <= cpu_addr;
              sd_din   <= cpu_din;
              op_write <= cpu_we;
              sd_rd    <= ~cpu_we;
              sd_we    <= cpu_we;
              if (!dma_pending)
                starve_cnt <= '0;
              else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        S_STROBE: begin
          state      <= S_SETTLE;
          settle_cnt <= SETTLE_INIT;
        end
        S_SETTLE: begin
          if (settle_cnt == '0)
            state <= S_WAIT;
          else
            settle_cnt <= settle_cnt - 1'b1;
        end
        default: begin
          if (sd_ready) begin
            state <= S_IDLE;
            if (grant) begin
              dma_ack <= 1'b1;
              if (!op_write) dma_dout <= sd_dout;
            end else begin
              cpu_ack <= 1'b1;
              if (!op_write) cpu_dout <= sd_dout;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench with a small SDRAM ready/data model.
`default_nettype none
`timescale 1ns/1ps
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] cpu_addr, dma_addr, sd_addr;
  logic [7:0]  cpu_din, dma_din, sd_din, cpu_dout, dma_dout, sd_dout;
  logic        cpu_rd, cpu_we, dma_rd, dma_we, cpu_ack, dma_ack;
  logic        sd_rd, sd_we, sd_ready;

  always #5 clk = ~clk;

  sdram_arbiter #(.SETTLE_CYCLES(2), .DMA_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_rd(cpu_rd), .cpu_we(cpu_we),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_rd(dma_rd), .dma_we(dma_we),
    .dma_dout(dma_dout), .dma_ack(dma_ack),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_rd(sd_rd), .sd_we(sd_we),
    .sd_dout(sd_dout), .sd_ready(sd_ready)
  );

  // Controller model: ready drops on a fresh strobe edge for busy_len cycles.
  int   busy_len  = 0;
  int   busy_cnt  = 0;
  logic m_ready   = 1'b1;
  logic prev_rd   = 1'b0;
  logic prev_we   = 1'b0;
  logic force_low = 1'b0;
  logic ack_gap   = 1'b0;
  logic [7:0] rdata = 8'h00;

  assign sd_dout  = rdata;
  assign sd_ready = m_ready & ~force_low & ~(ack_gap & (cpu_ack | dma_ack));

  always @(posedge clk) begin
    prev_rd <= sd_rd;
    prev_we <= sd_we;
    if ((sd_rd && !prev_rd) || (sd_we && !prev_we)) begin
      if (busy_len > 0) begin
        m_ready  <= 1'b0;
        busy_cnt <= busy_len - 1;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      m_ready <= 1'b1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(input bit dma, input int limit, output int n, output bit other);
    n = 0;
    other = 1'b0;
    do begin
      tick();
      n++;
      if (dma ? cpu_ack : dma_ack) other = 1'b1;
    end while (!(dma ? dma_ack : cpu_ack) && n < limit);
  endtask

  int  n;
  bit  other;
  bit  seen;
  bit  exp_dma [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    reset = 1'b1;
    cpu_addr = '0; cpu_din = '0; cpu_rd = 1'b0; cpu_we = 1'b0;
    dma_addr = '0; dma_din = '0; dma_rd = 1'b0; dma_we = 1'b0;
    force_low = 1'b1;
    repeat (3) tick();
    chk("rst_strobes", {30'd0, sd_rd, sd_we}, 32'h0);
    chk("rst_addr", {7'd0, sd_addr}, 32'h0);
    chk("rst_din", {24'd0, sd_din}, 32'h0);
    chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 32'h0);
    chk("rst_douts", {16'd0, cpu_dout, dma_dout}, 32'h0);

    // Controller busy after reset: no strobe until ready rises.
    reset = 1'b0;
    cpu_addr = 25'h000123; cpu_rd = 1'b1; busy_len = 6; rdata = 8'h5A;
    seen = 1'b0;
    repeat (4) begin tick(); if (sd_rd || sd_we) seen = 1'b1; end
    chk("busy_nostrobe", {31'd0, seen}, 32'h0);
    force_low = 1'b0;
    tick();
    chk("strobe_after_ready", {31'd0, sd_rd}, 32'h1);
    chk("rd_addr", {7'd0, sd_addr}, 32'h000123);
    chk("rd_no_we", {31'd0, sd_we}, 32'h0);
    tick();
    chk("rd_pulse_1cyc", {31'd0, sd_rd}, 32'h0);
    wait_ack(1'b0, 30, n, other);
    chk("rd_cpu_ack", {31'd0, cpu_ack}, 32'h1);
    chk("rd_cpu_dout", {24'd0, cpu_dout}, 32'h5A);
    chk("rd_no_dma_ack", {31'd0, other}, 32'h0);
    cpu_rd = 1'b0;
    tick();
    chk("rd_ack_1cyc", {31'd0, cpu_ack}, 32'h0);

    // Write with rd also high: write wins, dout untouched.
    cpu_addr = 25'h1000000; cpu_din = 8'hA5; cpu_we = 1'b1; cpu_rd = 1'b1; busy_len = 3;
    tick();
    chk("wr_we", {31'd0, sd_we}, 32'h1);
    chk("wr_no_rd", {31'd0, sd_rd}, 32'h0);
    chk("wr_din", {24'd0, sd_din}, 32'hA5);
    chk("wr_addr", {7'd0, sd_addr}, 32'h1000000);
    wait_ack(1'b0, 30, n, other);
    chk("wr_cpu_ack", {31'd0, cpu_ack}, 32'h1);
    chk("wr_dout_kept", {24'd0, cpu_dout}, 32'h5A);
    chk("wr_din_held", {24'd0, sd_din}, 32'hA5);
    cpu_we = 1'b0; cpu_rd = 1'b0;
    tick();
    chk("wr_ack_1cyc", {31'd0, cpu_ack}, 32'h0);

    // Same-word hit: ready never drops.
    busy_len = 0; rdata = 8'h77; cpu_addr = 25'h000124; cpu_rd = 1'b1;
    wait_ack(1'b0, 20, n, other);
    chk("hit_latency", n, 32'd5);
    chk("hit_dout", {24'd0, cpu_dout}, 32'h77);
    tick();
    chk("mask_no_regrant", {31'd0, sd_rd}, 32'h0);
    cpu_rd = 1'b0;
    tick();
    chk("mask_no_regrant2", {31'd0, sd_rd}, 32'h0);

    // Reset during WAIT while the controller is still busy.
    busy_len = 20; rdata = 8'h3C; cpu_addr = 25'h000200; cpu_rd = 1'b1;
    tick();
    chk("rst_test_strobe", {31'd0, sd_rd}, 32'h1);
    repeat (4) tick();
    reset = 1'b1; cpu_rd = 1'b0; dma_addr = 25'h0ABCDE; dma_rd = 1'b1;
    tick();
    chk("midrst_strobes", {30'd0, sd_rd, sd_we}, 32'h0);
    chk("midrst_acks", {30'd0, cpu_ack, dma_ack}, 32'h0);
    chk("midrst_cpu_dout", {24'd0, cpu_dout}, 32'h0);
    reset = 1'b0; busy_len = 2;
    seen = 1'b0;
    repeat (5) begin tick(); if (sd_rd || sd_we) seen = 1'b1; end
    chk("midrst_nostrobe", {31'd0, seen}, 32'h0);
    n = 0;
    do begin tick(); n++; end while (!sd_rd && n < 30);
    chk("dma_strobe", {31'd0, sd_rd}, 32'h1);
    chk("dma_strobe_ready", {31'd0, m_ready}, 32'h1);
    chk("dma_addr", {7'd0, sd_addr}, 32'h0ABCDE);
    wait_ack(1'b1, 30, n, other);
    chk("dma_ack", {31'd0, dma_ack}, 32'h1);
    chk("dma_dout", {24'd0, dma_dout}, 32'h3C);
    chk("dma_no_cpu_ack", {31'd0, other}, 32'h0);
    dma_rd = 1'b0;
    tick();

    // Continuous contention: CPU x4 then DMA.
    busy_len = 0; ack_gap = 1'b1; rdata = 8'h99;
    cpu_addr = 25'h000010; dma_addr = 25'h000020; cpu_rd = 1'b1; dma_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      do begin tick(); n++; end while (!(cpu_ack || dma_ack) && n < 20);
      chk($sformatf("order_%0d", i), {30'd0, cpu_ack, dma_ack},
          exp_dma[i] ? 32'h1 : 32'h2);
      tick();
      chk($sformatf("single_ack_%0d", i), {30'd0, cpu_ack, dma_ack}, 32'h0);
    end
    cpu_rd = 1'b0; dma_rd = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
